// File: rtl/lc3_mio_pkg.sv
// Shared constants and types for the LC-3 memory / memory-mapped I/O controller.
package lc3_mio_pkg;

    // Device register map; everything at or above DEV_BASE is device space.
    localparam logic [15:0] DEV_BASE  = 16'hFE00;
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // Status register bit positions (shared by KBSR and DSR).
    localparam int RDY_BIT = 15;
    localparam int IE_BIT  = 14;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK
    } state_t;

    // RAM occupies x0000..xFDFF; the top 512 words belong to devices.
    function automatic logic is_ram_addr(input logic [15:0] addr);
        return addr < DEV_BASE;
    endfunction

endpackage

// File: rtl/lc3_mem_io_if.sv
// Datapath-to-memory bus: request/handshake between MAR/MDR and the controller.
interface lc3_mem_io_if;

    logic        MIO_EN;
    logic        R_W;
    logic [15:0] a;
    logic [15:0] d_in;
    logic [15:0] mio_out;
    logic        R;

    // Datapath side issues requests and consumes read data / completion.
    modport master (
        output MIO_EN, R_W, a, d_in,
        input  mio_out, R
    );

    // Controller side services requests.
    modport slave (
        input  MIO_EN, R_W, a, d_in,
        output mio_out, R
    );

endinterface

// File: rtl/lc3_ram.sv
// Single-port RAM: synchronous write, registered one-cycle read.
module lc3_ram #(
    parameter int WORDS = 65536,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [WORDS];

    // Write or read on an enabled cycle; rdata holds between reads.
    // NOTE: the array and rdata carry no reset so the storage maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/lc3_mem_io.sv
// LC-3 memory and memory-mapped I/O controller: access FSM with RAM latency
// counter, keyboard/display device registers and the registered INT request.
module lc3_mem_io
    import lc3_mio_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_WORDS   = 65536
) (
    input  logic                clk,
    input  logic                reset,
    lc3_mem_io_if.slave         bus,
    output logic                INT,
    input  logic                kb_valid,
    input  logic [7:0]          kb_data,
    output logic                kb_ready,
    output logic                disp_valid,
    output logic [7:0]          disp_data,
    input  logic                disp_ready
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_LOAD = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] a_q;
    logic [15:0] d_q;
    logic        rw_q;
    logic        r_q;

    logic        kbsr_rdy, kbsr_ie;
    logic [7:0]  kbdr;
    logic        dsr_rdy, dsr_ie;
    logic [15:0] dev_q;
    logic        src_ram;

    logic        req_ram;
    logic        dev_go;
    logic        dev_rd;
    logic        ram_go;
    logic        ram_we;
    logic [15:0] ram_addr_full;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic [15:0] dev_rdata;

    // Decode of the live request; device operations complete on the accepting edge.
    assign req_ram = is_ram_addr(bus.a);
    assign dev_go  = !reset && (state == IDLE) && bus.MIO_EN && !req_ram;
    assign dev_rd  = dev_go && !bus.R_W;

    // The RAM operation fires on the edge into ACK; with single-cycle latency
    // that is the accepting edge, so the live bus feeds the RAM directly.
    assign ram_go = !reset &&
                    (((state == IDLE) && bus.MIO_EN && req_ram && (MEM_LATENCY == 1)) ||
                     ((state == WAIT) && (cnt == 4'd0)));
    assign ram_we        = (state == IDLE) ? bus.R_W  : rw_q;
    assign ram_addr_full = (state == IDLE) ? bus.a    : a_q;
    assign ram_wdata     = (state == IDLE) ? bus.d_in : d_q;

    lc3_ram #(
        .WORDS (MEM_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_go),
        .we    (ram_we),
        .addr  (ram_addr_full[AW-1:0]),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Device register read mux for the live address.
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    always_comb begin
        dev_rdata = '0;
        case (bus.a)
            KBSR_ADDR: begin
                dev_rdata[RDY_BIT] = kbsr_rdy;
                dev_rdata[IE_BIT]  = kbsr_ie;
            end
            KBDR_ADDR: dev_rdata[7:0] = kbdr;
            DSR_ADDR: begin
                dev_rdata[RDY_BIT] = dsr_rdy;
                dev_rdata[IE_BIT]  = dsr_ie;
            end
            default: dev_rdata = '0;
        endcase
    end

    // Access FSM: accept, count down RAM latency, pulse R for one cycle.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            a_q   <= '0;
            d_q   <= '0;
            rw_q  <= 1'b0;
            r_q   <= 1'b0;
        end else begin
            r_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.MIO_EN) begin
                        a_q  <= bus.a;
                        d_q  <= bus.d_in;
                        rw_q <= bus.R_W;
                        if (req_ram && (MEM_LATENCY > 1)) begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ACK;
                            r_q   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ACK;
                        r_q   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Device registers, read-data capture and the interrupt request.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbsr_rdy   <= 1'b0;
            kbsr_ie    <= 1'b0;
            kbdr       <= '0;
            dsr_rdy    <= 1'b1;
            dsr_ie     <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
            dev_q      <= '0;
            src_ram    <= 1'b0;
            INT        <= 1'b0;
        end else begin
            INT <= (kbsr_rdy & kbsr_ie) | (dsr_rdy & dsr_ie);

            // mio_out follows whichever source completed the latest read.
            if (dev_rd) begin
                dev_q   <= dev_rdata;
                src_ram <= 1'b0;
            end else if (ram_go && !ram_we) begin
                src_ram <= 1'b1;
            end

            // A KBDR read wins over a simultaneous strobe, which is dropped.
            if (dev_rd && (bus.a == KBDR_ADDR)) begin
                kbsr_rdy <= 1'b0;
            end else if (kb_valid && !kbsr_rdy) begin
                kbdr     <= kb_data;
                kbsr_rdy <= 1'b1;
            end

            if (dev_go && bus.R_W) begin
                case (bus.a)
                    KBSR_ADDR: kbsr_ie <= bus.d_in[IE_BIT];
                    DSR_ADDR:  dsr_ie  <= bus.d_in[IE_BIT];
                    DDR_ADDR: begin
                        if (dsr_rdy) begin
                            disp_data  <= bus.d_in[7:0];
                            disp_valid <= 1'b1;
                            dsr_rdy    <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (disp_valid && disp_ready) begin
                disp_valid <= 1'b0;
                dsr_rdy    <= 1'b1;
            end
        end
    end

    assign kb_ready    = ~kbsr_rdy;
    assign bus.R       = r_q;
    assign bus.mio_out = src_ram ? ram_rdata : dev_q;

endmodule

// File: tb/tb_lc3_mem_io.sv
// Self-checking bench for lc3_mem_io: directed device tests plus randomized
// RAM traffic checked against an address-indexed memory model.
module tb_lc3_mem_io;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       INT;
    logic       kb_valid;
    logic [7:0] kb_data;
    logic       kb_ready;
    logic       disp_valid;
    logic [7:0] disp_data;
    logic       disp_ready;

    int checks   = 0;
    int failures = 0;

    lc3_mem_io_if bus ();

    lc3_mem_io #(
        .MEM_LATENCY (LAT),
        .MEM_WORDS   (65536)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .INT        (INT),
        .kb_valid   (kb_valid),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .disp_ready (disp_ready)
    );

    always #5 clk = ~clk;

    // Reference memory: last value written to each RAM address.
    logic [15:0] ram_m [int];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete access; starts and ends on a falling edge, checks latency
    // and that R drops again the following cycle.
    task automatic access(input logic rw, input logic [15:0] addr, input logic [15:0] wd,
                          input int exp_lat, input string tag, output logic [15:0] rd);
        int cyc;
        bit seen;
        bus.MIO_EN = 1'b1;
        bus.R_W    = rw;
        bus.a      = addr;
        bus.d_in   = wd;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.R === 1'b1) seen = 1'b1;
        end
        bus.MIO_EN = 1'b0;
        rd = bus.mio_out;
        chk({tag, "_lat"}, 16'(cyc), 16'(exp_lat));
        @(negedge clk);
        chk({tag, "_pulse"}, {15'b0, bus.R}, 16'h0000);
    endtask

    task automatic kb_strobe(input logic [7:0] c);
        kb_valid = 1'b1;
        kb_data  = c;
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        logic [15:0] addr, val;
        logic [7:0]  c;
        bit          kb_full;
        logic [7:0]  kb_char;
        int          t;
        bit          seen;

        reset      = 1'b1;
        bus.MIO_EN = 1'b0;
        bus.R_W    = 1'b0;
        bus.a      = '0;
        bus.d_in   = '0;
        kb_valid   = 1'b0;
        kb_data    = '0;
        disp_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_R", {15'b0, bus.R}, 16'h0);
        chk("rst_mio_out", bus.mio_out, 16'h0000);
        chk("rst_INT", {15'b0, INT}, 16'h0);
        chk("rst_kb_ready", {15'b0, kb_ready}, 16'h1);
        chk("rst_disp_valid", {15'b0, disp_valid}, 16'h0);
        chk("rst_disp_data", {8'b0, disp_data}, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        access(1'b0, 16'hFE04, 16'h0, 1, "rst_dsr", rd);
        chk("rst_dsr_val", rd, 16'h8000);
        access(1'b0, 16'hFE00, 16'h0, 1, "rst_kbsr", rd);
        chk("rst_kbsr_val", rd, 16'h0000);

        // RAM write then read
        access(1'b1, 16'h3000, 16'h1234, LAT, "ram_wr", rd);
        ram_m[16'h3000] = 16'h1234;
        access(1'b0, 16'h3000, 16'h0, LAT, "ram_rd", rd);
        chk("ram_rd_val", rd, 16'h1234);

        // Boundaries of the address map
        access(1'b1, 16'hFDFF, 16'hA5C3, LAT, "ram_top_wr", rd);
        access(1'b1, 16'h0000, 16'h5A3C, LAT, "ram_bot_wr", rd);
        access(1'b0, 16'hFDFF, 16'h0, LAT, "ram_top_rd", rd);
        chk("ram_top_val", rd, 16'hA5C3);
        access(1'b0, 16'h0000, 16'h0, LAT, "ram_bot_rd", rd);
        chk("ram_bot_val", rd, 16'h5A3C);
        access(1'b1, 16'hFE08, 16'hFFFF, 1, "unmap_wr", rd);
        access(1'b0, 16'hFE08, 16'h0, 1, "unmap_rd", rd);
        chk("unmap_val", rd, 16'h0000);
        access(1'b0, 16'hFFFE, 16'h0, 1, "unmap_hi_rd", rd);
        chk("unmap_hi_val", rd, 16'h0000);

        // Randomized RAM traffic over a small window
        for (int i = 0; i < 8; i++) begin
            addr = 16'h3000 + 16'(i);
            val  = 16'($urandom);
            access(1'b1, addr, val, LAT, "rnd_seed", rd);
            ram_m[addr] = val;
        end
        for (int i = 0; i < 24; i++) begin
            addr = 16'h3000 + 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                val = 16'($urandom);
                access(1'b1, addr, val, LAT, "rnd_wr", rd);
                ram_m[addr] = val;
            end else begin
                access(1'b0, addr, 16'h0, LAT, "rnd_rd", rd);
                chk("rnd_rd_val", rd, ram_m[addr]);
            end
        end

        // Back-to-back: hold MIO_EN, write then read the same address
        bus.MIO_EN = 1'b1;
        bus.R_W    = 1'b1;
        bus.a      = 16'h3010;
        bus.d_in   = 16'h1111;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 40) begin
            @(negedge clk);
            t++;
            if (bus.R === 1'b1) seen = 1'b1;
        end
        chk("b2b_first_lat", 16'(t), 16'(LAT));
        bus.R_W = 1'b0;
        t = 0;
        seen = 1'b0;
        while (!seen && t < 40) begin
            @(negedge clk);
            t++;
            if (bus.R === 1'b1) seen = 1'b1;
        end
        bus.MIO_EN = 1'b0;
        chk("b2b_gap", 16'(t), 16'(LAT + 1));
        chk("b2b_raw_val", bus.mio_out, 16'h1111);
        @(negedge clk);

        // Keyboard path
        kb_strobe(8'h41);
        chk("kb_ready_full", {15'b0, kb_ready}, 16'h0);
        access(1'b0, 16'hFE00, 16'h0, 1, "kbsr_full", rd);
        chk("kbsr_full_val", rd, 16'h8000);
        kb_strobe(8'h42);
        access(1'b0, 16'hFE02, 16'h0, 1, "kbdr_rd", rd);
        chk("kbdr_val", rd, 16'h0041);
        access(1'b0, 16'hFE00, 16'h0, 1, "kbsr_empty", rd);
        chk("kbsr_empty_val", rd, 16'h0000);
        chk("kb_ready_empty", {15'b0, kb_ready}, 16'h1);

        // Randomized keyboard bursts: only the first strobe into an empty KBDR sticks
        for (int i = 0; i < 4; i++) begin
            kb_full = 1'b0;
            kb_char = '0;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                c = 8'($urandom);
                kb_strobe(c);
                if (!kb_full) begin
                    kb_full = 1'b1;
                    kb_char = c;
                end
            end
            chk("kb_rnd_ready", {15'b0, kb_ready}, {15'b0, !kb_full});
            access(1'b0, 16'hFE02, 16'h0, 1, "kb_rnd_rd", rd);
            chk("kb_rnd_val", rd, {8'h00, kb_char});
        end

        // Display path
        access(1'b1, 16'hFE06, 16'h0058, 1, "ddr_wr", rd);
        chk("disp_valid_set", {15'b0, disp_valid}, 16'h1);
        chk("disp_data_set", {8'b0, disp_data}, 16'h0058);
        access(1'b0, 16'hFE04, 16'h0, 1, "dsr_busy", rd);
        chk("dsr_busy_val", rd, 16'h0000);
        access(1'b1, 16'hFE06, 16'h0059, 1, "ddr_drop", rd);
        chk("disp_data_kept", {8'b0, disp_data}, 16'h0058);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        chk("disp_valid_clr", {15'b0, disp_valid}, 16'h0);
        access(1'b0, 16'hFE04, 16'h0, 1, "dsr_ready", rd);
        chk("dsr_ready_val", rd, 16'h8000);

        // Keyboard interrupt
        access(1'b1, 16'hFE00, 16'h4000, 1, "kbsr_ie_wr", rd);
        chk("int_idle", {15'b0, INT}, 16'h0);
        kb_strobe(8'h55);
        chk("int_lag", {15'b0, INT}, 16'h0);
        @(negedge clk);
        chk("int_set", {15'b0, INT}, 16'h1);
        access(1'b0, 16'hFE02, 16'h0, 1, "int_kbdr_rd", rd);
        chk("int_kbdr_val", rd, 16'h0055);
        chk("int_clr", {15'b0, INT}, 16'h0);
        access(1'b1, 16'hFE00, 16'h0000, 1, "kbsr_ie_off", rd);

        // Display interrupt (DSR ready is set, so enabling raises INT)
        access(1'b1, 16'hFE04, 16'h4000, 1, "dsr_ie_wr", rd);
        chk("dsr_int_set", {15'b0, INT}, 16'h1);
        access(1'b1, 16'hFE04, 16'h0000, 1, "dsr_ie_off", rd);
        chk("dsr_int_clr", {15'b0, INT}, 16'h0);

        // Reset during WAIT aborts a RAM write
        access(1'b1, 16'h3001, 16'h0A0A, LAT, "abort_pre", rd);
        bus.MIO_EN = 1'b1;
        bus.R_W    = 1'b1;
        bus.a      = 16'h3001;
        bus.d_in   = 16'hBEEF;
        @(negedge clk);
        reset      = 1'b1;
        bus.MIO_EN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_R_rst", {15'b0, bus.R}, 16'h0);
        end
        reset = 1'b0;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            chk("abort_R_after", {15'b0, bus.R}, 16'h0);
        end
        access(1'b0, 16'h3001, 16'h0, LAT, "abort_rd", rd);
        chk("abort_val", rd, 16'h0A0A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lc3_mem_io.md
# lc3_mem_io

Memory and memory-mapped I/O controller for the LC-3 datapath. It sits directly downstream of the datapath's MAR/MDR. It accepts one access per `MIO_EN` request, services it from an internal RAM or from the keyboard/display device registers, returns read data on `mio_out`, and pulses `R` when the access completes. It also produces the level-sensitive `INT` request that the control unit samples.

## Interface
- `MEM_LATENCY`, default 4: cycles from request acceptance to `R` for RAM accesses; legal range 1..15.
- `MEM_WORDS`, default 65536: RAM depth; power of two.
- `clk` in 1: the single clock.
- `reset` in 1: reset is synchronous and active-high.
- `MIO_EN` in 1: access request, level, held by the datapath until `R`.
- `R_W` in 1: 1 = write, 0 = read; sampled with `MIO_EN`.
- `a` in 16: word address (MAR).
- `d_in` in 16: write data (MDR).
- `mio_out` out 16: read data; valid in the `R` cycle and held until the next read completes.
- `R` out 1: access complete, one-cycle pulse.
- `INT` out 1: registered interrupt request.
- `kb_valid` in 1: keyboard character strobe.
- `kb_data` in 8: keyboard character.
- `kb_ready` out 1: equals ~KBSR[15].
- `disp_valid` out 1: display character pending.
- `disp_data` out 8: display character.
- `disp_ready` in 1: display accepts the character when `disp_valid` and `disp_ready` are both 1.

## Operation
- Address map:
  - RAM covers x0000–xFDFF. The RAM index is `a` truncated to log2(`MEM_WORDS`) bits, so addresses alias (wrap) modulo depth.
  - KBSR is at xFE00. Bit 15 is ready (read-only). Bit 14 is IE (read/write).
  - KBDR is at xFE02. Bits [7:0] hold the character; bits [15:8] read as 0.
  - DSR is at xFE04. Bit 15 is ready (read-only). Bit 14 is IE (read/write).
  - DDR is at xFE06. Writing it sends a character to the display.
  - Any other address in xFE08–xFFFF reads 0 and ignores writes.
- FSM states are IDLE, WAIT and ACK.
  - IDLE: when `MIO_EN`=1, latch `a`, `d_in` and `R_W`. For a RAM access with `MEM_LATENCY`>1, go to WAIT with the counter loaded to `MEM_LATENCY`-2. For a device access, or when `MEM_LATENCY`=1, go to ACK.
  - WAIT: decrement the counter. At 0, issue the RAM operation and go to ACK. `MIO_EN` is ignored while in WAIT.
  - ACK: `R`=1 and `mio_out` is updated for reads. A write takes architectural effect in this cycle. The next state is always IDLE.
  - A new request is accepted no earlier than the cycle after ACK.
- Keyboard:
  - When `kb_valid`=1 and KBSR[15]=0, load KBDR ← `kb_data` and set KBSR[15].
  - When `kb_valid`=1 and KBSR[15]=1, the character is dropped.
  - Completing a read of KBDR clears KBSR[15] in the ACK cycle. A `kb_valid` in that same cycle is dropped.
- Display:
  - A DDR write while DSR[15]=1 sets `disp_data` ← `d_in`[7:0], sets `disp_valid`=1 and clears DSR[15].
  - A DDR write while DSR[15]=0 is discarded, but `R` still pulses.
  - A handshake (`disp_valid`&`disp_ready`) clears `disp_valid` and sets DSR[15] on the next edge.
- Interrupt: `INT` ← (KBSR[15]&KBSR[14]) | (DSR[15]&DSR[14]), registered.
- Reset values:
  - FSM state IDLE, `R`=0, `mio_out`=0, `INT`=0.
  - KBSR=0, KBDR=0, DSR=x8000.
  - `disp_valid`=0, `disp_data`=0, `kb_ready`=1.
  - RAM contents are not reset.
- Reset in WAIT or ACK aborts the access: no write occurs and `R` stays 0.

## Timing
- Request sampled in cycle 0:
  - RAM access: `R` rises in cycle `MEM_LATENCY`.
  - Device or unmapped access: `R` rises in cycle 1.
- `R` is high for exactly one cycle per accepted request.
- Back-to-back requests: with `MIO_EN` held high, the next request is accepted in the cycle after `R`. RAM throughput is one access per `MEM_LATENCY`+1 cycles.
- Status bits, `kb_ready` and `INT` reflect register state with one edge of delay after any event.
- A RAM read-after-write to the same address returns the new data.

## Structure
- Package `lc3_mio_pkg` holds:
  - the address constants `KBSR_ADDR`, `KBDR_ADDR`, `DSR_ADDR`, `DDR_ADDR` and `DEV_BASE` (xFE00);
  - the state enum {IDLE, WAIT, ACK};
  - the bit positions `RDY_BIT`=15 and `IE_BIT`=14.
- Sub-module `lc3_ram`: single-port, synchronous write, registered 1-cycle read, depth `MEM_WORDS`.
- Top level contains the FSM, latency counter, address decode, device registers and INT register.

## Test plan
- Reset: assert `reset` 2 cycles → `R`=0, `mio_out`=0, `INT`=0, DSR reads x8000, KBSR reads x0000, `kb_ready`=1.
- RAM write then read, `MEM_LATENCY`=4: write x1234 to x3000, `R` in cycle 4 → read x3000 returns `mio_out`=x1234 with `R` in cycle 4 of the second request.
- Keyboard path:
  - `kb_valid` with x41 → KBSR reads x8000 and `kb_ready`=0.
  - A second `kb_valid` with x42 is dropped.
  - Read KBDR → x0041; afterwards KBSR reads x0000.
- Display path:
  - Write DDR x0058 → `disp_valid`=1, `disp_data`=x58, DSR=x0000.
  - A second DDR write is discarded.
  - Hold `disp_ready` 1 cycle → `disp_valid`=0, DSR=x8000.
- Interrupt: write KBSR x4000, then `kb_valid` → `INT`=1 one edge after KBSR[15] sets; read KBDR → `INT`=0.
- Abort: issue a RAM write to x3001, assert `reset` during WAIT → no `R`; a following read of x3001 returns the pre-test value.
